// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO, arbitrary depth, programmable almost-full/empty, occupancy and high-watermark.
// Registered read data (1 cycle after the read edge); writes rejected when full, reads rejected when empty.
module fifo_sync_prog #(
  parameter  int FIFO_WIDTH = 16,
  parameter  int FIFO_DEPTH = 8,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_wr_en,
  input  logic [FIFO_WIDTH-1:0] i_data_in,
  input  logic                  i_rd_en,
  input  logic [CNT_W-1:0]      i_af_level,
  input  logic [CNT_W-1:0]      i_ae_level,
  output logic [FIFO_WIDTH-1:0] o_data_out,
  output logic                  o_wr_ack,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almostfull,
  output logic                  o_almostempty,
  output logic [CNT_W-1:0]      o_count,
  output logic [CNT_W-1:0]      o_max_count
);

  localparam int              PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_max_count;
  logic [FIFO_WIDTH-1:0] r_data_out;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_acc_wr;
  logic                  w_acc_rd;
  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;
  logic [CNT_W-1:0]      w_count_nxt;

  assign w_full   = (r_count == DEPTH_CNT);
  assign w_empty  = (r_count == '0);
  // A read never frees space for a same-cycle write when full, so gating on the flags alone suffices.
  assign w_acc_wr = i_wr_en && !w_full;
  assign w_acc_rd = i_rd_en && !w_empty;

  // Pointers wrap explicitly so depths that are not a power of two work.
  assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
  assign w_count_nxt  = r_count + CNT_W'(w_acc_wr) - CNT_W'(w_acc_rd);

  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush && w_acc_wr) begin
      r_mem[r_wr_ptr] <= i_data_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_max_count <= '0;
      r_data_out  <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_max_count <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_acc_wr) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_acc_rd) begin
        r_rd_ptr   <= w_rd_ptr_nxt;
        r_data_out <= r_mem[r_rd_ptr];
      end
      r_count <= w_count_nxt;
      if (w_count_nxt > r_max_count) begin
        r_max_count <= w_count_nxt;
      end
      r_wr_ack    <= w_acc_wr;
      r_overflow  <= i_wr_en && !w_acc_wr;
      r_underflow <= i_rd_en && !w_acc_rd;
    end
  end

  assign o_data_out    = r_data_out;
  assign o_wr_ack      = r_wr_ack;
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;
  assign o_count       = r_count;
  assign o_max_count   = r_max_count;
  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_almostfull  = (i_af_level != '0) && (r_count >= i_af_level);
  assign o_almostempty = (r_count <= i_ae_level) && !w_empty;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: vector table on an 8-deep instance, hand sequences on a 5-deep instance.
module tb_fifo_sync_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // 8-deep instance
  logic        a_rst, a_flush, a_wr_en, a_rd_en;
  logic [15:0] a_data_in, a_data_out;
  logic [3:0]  a_af_level, a_ae_level, a_count, a_max_count;
  logic        a_wr_ack, a_overflow, a_underflow, a_full, a_empty, a_almostfull, a_almostempty;

  // 5-deep instance
  logic        b_rst, b_flush, b_wr_en, b_rd_en;
  logic [15:0] b_data_in, b_data_out;
  logic [2:0]  b_af_level, b_ae_level, b_count, b_max_count;
  logic        b_wr_ack, b_overflow, b_underflow, b_full, b_empty, b_almostfull, b_almostempty;

  fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) u_d8 (
    .i_clk(clk), .i_rst(a_rst), .i_flush(a_flush), .i_wr_en(a_wr_en), .i_data_in(a_data_in),
    .i_rd_en(a_rd_en), .i_af_level(a_af_level), .i_ae_level(a_ae_level),
    .o_data_out(a_data_out), .o_wr_ack(a_wr_ack), .o_overflow(a_overflow), .o_underflow(a_underflow),
    .o_full(a_full), .o_empty(a_empty), .o_almostfull(a_almostfull), .o_almostempty(a_almostempty),
    .o_count(a_count), .o_max_count(a_max_count)
  );

  fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) u_d5 (
    .i_clk(clk), .i_rst(b_rst), .i_flush(b_flush), .i_wr_en(b_wr_en), .i_data_in(b_data_in),
    .i_rd_en(b_rd_en), .i_af_level(b_af_level), .i_ae_level(b_ae_level),
    .o_data_out(b_data_out), .o_wr_ack(b_wr_ack), .o_overflow(b_overflow), .o_underflow(b_underflow),
    .o_full(b_full), .o_empty(b_empty), .o_almostfull(b_almostfull), .o_almostempty(b_almostempty),
    .o_count(b_count), .o_max_count(b_max_count)
  );

  // ctl = {rst, flush, wr_en, rd_en}; pulses = {wr_ack, overflow, underflow};
  // flags = {full, empty, almostfull, almostempty}
  typedef struct {
    logic [3:0]  ctl;
    logic [15:0] din;
    logic [3:0]  af;
    logic [3:0]  ae;
    logic [15:0] dout;
    logic [2:0]  pulses;
    logic [3:0]  flags;
    logic [3:0]  cnt;
    logic [3:0]  mx;
  } vec_t;

  vec_t vecs[$];

  localparam logic [3:0] AF = 4'd6;
  localparam logic [3:0] AE = 4'd2;

  task automatic add(input logic [3:0] ctl, input logic [15:0] din, input logic [3:0] af,
                     input logic [3:0] ae, input logic [15:0] dout, input logic [2:0] pulses,
                     input logic [3:0] flags, input logic [3:0] cnt, input logic [3:0] mx);
    vec_t v;
    v.ctl = ctl; v.din = din; v.af = af; v.ae = ae; v.dout = dout;
    v.pulses = pulses; v.flags = flags; v.cnt = cnt; v.mx = mx;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step5(input logic w, input logic r, input logic [15:0] d);
    b_wr_en   = w;
    b_rd_en   = r;
    b_data_in = d;
    tick();
  endtask

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_data_in = '0;
    a_af_level = AF; a_ae_level = AE;
    b_rst = 1'b1; b_flush = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_data_in = '0;
    b_af_level = 3'd0; b_ae_level = 3'd0;

    // reset, fill to full with thresholds 6/2, overflow, af_level=0 disables
    add(4'b1000, 16'h0000, AF, AE, 16'h0000, 3'b000, 4'b0100, 4'd0, 4'd0);
    add(4'b0010, 16'h0001, AF, AE, 16'h0000, 3'b100, 4'b0001, 4'd1, 4'd1);
    add(4'b0010, 16'h0002, AF, AE, 16'h0000, 3'b100, 4'b0001, 4'd2, 4'd2);
    add(4'b0010, 16'h0003, AF, AE, 16'h0000, 3'b100, 4'b0000, 4'd3, 4'd3);
    add(4'b0010, 16'h0004, AF, AE, 16'h0000, 3'b100, 4'b0000, 4'd4, 4'd4);
    add(4'b0010, 16'h0005, AF, AE, 16'h0000, 3'b100, 4'b0000, 4'd5, 4'd5);
    add(4'b0010, 16'h0006, AF, AE, 16'h0000, 3'b100, 4'b0010, 4'd6, 4'd6);
    add(4'b0010, 16'h0007, AF, AE, 16'h0000, 3'b100, 4'b0010, 4'd7, 4'd7);
    add(4'b0010, 16'h0008, AF, AE, 16'h0000, 3'b100, 4'b1010, 4'd8, 4'd8);
    add(4'b0010, 16'h0009, AF, AE, 16'h0000, 3'b010, 4'b1010, 4'd8, 4'd8);
    add(4'b0000, 16'h0000, 4'd0, AE, 16'h0000, 3'b000, 4'b1000, 4'd8, 4'd8);
    // drain in order
    add(4'b0001, 16'h0000, AF, AE, 16'h0001, 3'b000, 4'b0010, 4'd7, 4'd8);
    add(4'b0001, 16'h0000, AF, AE, 16'h0002, 3'b000, 4'b0010, 4'd6, 4'd8);
    add(4'b0001, 16'h0000, AF, AE, 16'h0003, 3'b000, 4'b0000, 4'd5, 4'd8);
    add(4'b0001, 16'h0000, AF, AE, 16'h0004, 3'b000, 4'b0000, 4'd4, 4'd8);
    add(4'b0001, 16'h0000, AF, AE, 16'h0005, 3'b000, 4'b0000, 4'd3, 4'd8);
    add(4'b0001, 16'h0000, AF, AE, 16'h0006, 3'b000, 4'b0001, 4'd2, 4'd8);
    add(4'b0001, 16'h0000, AF, AE, 16'h0007, 3'b000, 4'b0001, 4'd1, 4'd8);
    add(4'b0001, 16'h0000, AF, AE, 16'h0008, 3'b000, 4'b0100, 4'd0, 4'd8);
    add(4'b0001, 16'h0000, AF, AE, 16'h0008, 3'b001, 4'b0100, 4'd0, 4'd8);
    // empty with wr+rd: write wins, read underflows
    add(4'b0011, 16'h00AA, AF, AE, 16'h0008, 3'b101, 4'b0001, 4'd1, 4'd8);
    // watermark then flush with a write pending
    add(4'b1000, 16'h0000, AF, AE, 16'h0000, 3'b000, 4'b0100, 4'd0, 4'd0);
    add(4'b0010, 16'h0011, AF, AE, 16'h0000, 3'b100, 4'b0001, 4'd1, 4'd1);
    add(4'b0010, 16'h0012, AF, AE, 16'h0000, 3'b100, 4'b0001, 4'd2, 4'd2);
    add(4'b0010, 16'h0013, AF, AE, 16'h0000, 3'b100, 4'b0000, 4'd3, 4'd3);
    add(4'b0010, 16'h0014, AF, AE, 16'h0000, 3'b100, 4'b0000, 4'd4, 4'd4);
    add(4'b0010, 16'h0015, AF, AE, 16'h0000, 3'b100, 4'b0000, 4'd5, 4'd5);
    add(4'b0010, 16'h0016, AF, AE, 16'h0000, 3'b100, 4'b0010, 4'd6, 4'd6);
    add(4'b0010, 16'h0017, AF, AE, 16'h0000, 3'b100, 4'b0010, 4'd7, 4'd7);
    add(4'b0001, 16'h0000, AF, AE, 16'h0011, 3'b000, 4'b0010, 4'd6, 4'd7);
    add(4'b0001, 16'h0000, AF, AE, 16'h0012, 3'b000, 4'b0000, 4'd5, 4'd7);
    add(4'b0001, 16'h0000, AF, AE, 16'h0013, 3'b000, 4'b0000, 4'd4, 4'd7);
    add(4'b0110, 16'h0055, AF, AE, 16'h0013, 3'b000, 4'b0100, 4'd0, 4'd0);
    add(4'b0010, 16'h0066, AF, AE, 16'h0013, 3'b100, 4'b0001, 4'd1, 4'd1);
    add(4'b0001, 16'h0000, AF, AE, 16'h0066, 3'b000, 4'b0100, 4'd0, 4'd1);
    // reset mid-stream at count 4 with wr+rd active, then nothing was kept
    add(4'b0010, 16'h0021, AF, AE, 16'h0066, 3'b100, 4'b0001, 4'd1, 4'd1);
    add(4'b0010, 16'h0022, AF, AE, 16'h0066, 3'b100, 4'b0001, 4'd2, 4'd2);
    add(4'b0010, 16'h0023, AF, AE, 16'h0066, 3'b100, 4'b0000, 4'd3, 4'd3);
    add(4'b0010, 16'h0024, AF, AE, 16'h0066, 3'b100, 4'b0000, 4'd4, 4'd4);
    add(4'b1011, 16'h0099, AF, AE, 16'h0000, 3'b000, 4'b0100, 4'd0, 4'd0);
    add(4'b0001, 16'h0000, AF, AE, 16'h0000, 3'b001, 4'b0100, 4'd0, 4'd0);

    foreach (vecs[i]) begin
      {a_rst, a_flush, a_wr_en, a_rd_en} = vecs[i].ctl;
      a_data_in  = vecs[i].din;
      a_af_level = vecs[i].af;
      a_ae_level = vecs[i].ae;
      tick();
      check($sformatf("v%0d data_out", i), 32'(a_data_out), 32'(vecs[i].dout));
      check($sformatf("v%0d pulses", i), 32'({a_wr_ack, a_overflow, a_underflow}), 32'(vecs[i].pulses));
      check($sformatf("v%0d flags", i),
            32'({a_full, a_empty, a_almostfull, a_almostempty}), 32'(vecs[i].flags));
      check($sformatf("v%0d count", i), 32'(a_count), 32'(vecs[i].cnt));
      check($sformatf("v%0d max_count", i), 32'(a_max_count), 32'(vecs[i].mx));
    end
    a_rst = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;

    // 5-deep: prefill 3, then 12 wr+rd cycles across several pointer wraps
    b_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step5(1'b1, 1'b0, 16'(16'h0100 + k));
      check("d5 prefill count", 32'(b_count), 32'(k + 1));
    end
    for (int i = 0; i < 12; i++) begin
      step5(1'b1, 1'b1, 16'(16'h0103 + i));
      check($sformatf("d5 wrap dout %0d", i), 32'(b_data_out), 32'(16'h0100 + i));
      check($sformatf("d5 wrap count %0d", i), 32'(b_count), 32'd3);
      check($sformatf("d5 wrap ack %0d", i), 32'(b_wr_ack), 32'd1);
    end
    step5(1'b1, 1'b0, 16'h010F);
    step5(1'b1, 1'b0, 16'h0110);
    check("d5 full", 32'(b_full), 32'd1);
    check("d5 full count", 32'(b_count), 32'd5);

    // full with wr+rd: oldest word out, write rejected
    step5(1'b1, 1'b1, 16'h01FF);
    check("d5 full rw dout", 32'(b_data_out), 32'h010C);
    check("d5 full rw overflow", 32'(b_overflow), 32'd1);
    check("d5 full rw wr_ack", 32'(b_wr_ack), 32'd0);
    check("d5 full rw count", 32'(b_count), 32'd4);

    for (int i = 0; i < 4; i++) begin
      step5(1'b0, 1'b1, 16'h0000);
      check($sformatf("d5 drain %0d", i), 32'(b_data_out), 32'(16'h010D + i));
    end
    check("d5 empty", 32'(b_empty), 32'd1);
    check("d5 max_count", 32'(b_max_count), 32'd5);
    step5(1'b0, 1'b0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_prog.md
# fifo_sync_prog

Parametrised synchronous FIFO, the next generation of the team's verified 16x8 FIFO. It adds arbitrary (non-power-of-2) depth, runtime-programmable almost-full/almost-empty thresholds, an occupancy count, a high-watermark register and a synchronous flush. It sits between a producer and consumer in one clock domain and keeps the established handshake: registered `data_out`, `wr_ack`, `overflow`, `underflow`.

## Interface
Parameters:
- `FIFO_WIDTH`, 16: data width in bits, ≥1.
- `FIFO_DEPTH`, 8: number of entries, ≥2, need not be a power of 2.
- `CNT_W`, `$clog2(FIFO_DEPTH+1)`: width of the count and threshold fields (localparam).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `flush`  in  1: synchronous clear of contents.
- `wr_en`  in  1: write request.
- `data_in`  in  FIFO_WIDTH: write data.
- `rd_en`  in  1: read request.
- `af_level`  in  CNT_W: almost-full threshold; 0 disables the flag.
- `ae_level`  in  CNT_W: almost-empty threshold.
- `data_out`  out  FIFO_WIDTH: read data, registered.
- `wr_ack`  out  1: write accepted last cycle.
- `overflow`  out  1: write rejected last cycle.
- `underflow`  out  1: read rejected last cycle.
- `full`, `empty`  out  1: occupancy flags.
- `almostfull`, `almostempty`  out  1: threshold flags.
- `count`  out  CNT_W: current occupancy, 0..FIFO_DEPTH.
- `max_count`  out  CNT_W: highest `count` since the last reset or flush.

## Operation
- Storage: FIFO_DEPTH x FIFO_WIDTH array. `wr_ptr` and `rd_ptr` run 0..FIFO_DEPTH-1 and wrap explicitly to 0 after FIFO_DEPTH-1. Modulo-2^n wrap is forbidden.
- A write is accepted when `wr_en` && (!full || accepted read this cycle is not allowed). In short, a write is accepted only if !full.
- A read is accepted when `rd_en` && !empty.
- Simultaneous requests:
  - Full with wr+rd: the read is accepted and the write is rejected (`overflow`).
  - Empty with wr+rd: the write is accepted and the read is rejected (`underflow`).
  - Otherwise both are accepted and `count` is unchanged.
- `count` next value = count + acc_wr − acc_rd.
- `max_count` loads the next `count` whenever it exceeds the current `max_count`.
- Accepted read: `data_out` <= mem[rd_ptr]. Otherwise `data_out` holds its value.
- `wr_ack`, `overflow` and `underflow` are registered single-cycle pulses for the request of the previous cycle.
- Flag decode, combinational from `count`:
  - `full` = (count == FIFO_DEPTH).
  - `empty` = (count == 0).
  - `almostfull` = (af_level != 0) && (count >= af_level).
  - `almostempty` = (count <= ae_level) && !empty.
- `flush`, when high and `rst` is low: pointers, `count` and `max_count` go to 0. `wr_en`/`rd_en` are ignored that cycle. `wr_ack`/`overflow`/`underflow` are 0 next cycle. `data_out` holds; memory contents are don't-care.
- Priority: `rst` > `flush` > `wr_en`/`rd_en`.

## Timing
- Reset values after a `rst` edge:
  - `data_out` = 0, `wr_ack` = `overflow` = `underflow` = 0.
  - `count` = `max_count` = 0, `empty` = 1, `full` = 0, `almostfull` = 0, `almostempty` = 0.
- Reset mid-operation discards all contents at the next edge, with no partial write.
- Write-to-read latency: data written at edge N is readable by `rd_en` sampled at edge N+1. It appears on `data_out` after edge N+1 (1 cycle after the read edge).
- Flags and `count` update in the same cycle as the accepting edge.
- Threshold inputs are sampled continuously. A change affects the flags combinationally with no pipeline.

## Test plan
- Reset then fill, DEPTH=8: 8 writes of 1..8 → `wr_ack`=1 each, `count` 1..8, `full`=1 after the 8th. A 9th write → `overflow`=1, `count`=8. Then 8 reads → `data_out` 1..8 in order, `empty`=1.
- Non-power-of-2 wrap, DEPTH=5: run 12 interleaved write/read cycles across the pointer wrap → data order preserved and `count` never exceeds 5.
- Simultaneous boundaries:
  - Full with wr+rd → read returns the oldest word, `overflow`=1, `count` stays 5 minus 1 = 4 for DEPTH=5.
  - Empty with wr+rd → `underflow`=1, `wr_ack`=1, `count`=1.
- Thresholds, DEPTH=8, `af_level`=6, `ae_level`=2: `almostfull` rises at count 6, `almostempty` is high at counts 1..2 and low at 0 and 3. With `af_level`=0, `almostfull` stays 0 at count 8.
- Flush/watermark: write 7 words, read 3 → `max_count`=7. Assert `flush` with `wr_en`=1 → `count`=0, `max_count`=0, `wr_ack`=0, and `data_out` keeps its last value.
- Reset mid-stream: raise `rst` while `count`=4 with wr/rd active → every output takes its reset value at the next edge.
